// File: rtl/fu_issue_buffer_pkg.sv
// Shared types and sizing for the FU issue buffer.
// - Lane and FU counts for the issue stage.
// - fu_class_e: target functional-unit class of an issued packet.
// - fu_packet_t: packet handed from the RS to an FU (valid bit is the first field).
// - ib_entry_t: one buffer entry, a packet tagged with its FU class.
package fu_issue_buffer_pkg;

    localparam int unsigned N            = 3;
    localparam int unsigned NUM_FU_ALU   = 3;
    localparam int unsigned NUM_FU_MULT  = 2;
    localparam int unsigned NUM_FU_LOAD  = 1;
    localparam int unsigned NUM_FU_STORE = 1;
    localparam int unsigned ROB_IDX_W    = 5;

    typedef enum logic [1:0] {
        FU_ALU   = 2'd0,
        FU_MULT  = 2'd1,
        FU_LOAD  = 2'd2,
        FU_STORE = 2'd3
    } fu_class_e;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] robn;
        logic [3:0]           func;
        logic [4:0]           dest_preg;
        logic [31:0]          opa;
        logic [31:0]          opb;
    } fu_packet_t;

    typedef struct packed {
        fu_packet_t pkt;
        fu_class_e  cls;
    } ib_entry_t;

    // Number of lanes carrying a valid packet this cycle.
    function automatic int unsigned count_valid_lanes(input fu_packet_t [N-1:0] lanes);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned l = 0; l < N; l++) begin
            if (lanes[l].valid) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fu_issue_buffer_grant.sv
// Per-class grant for the issue buffer.
// The k-th oldest matching entry (lowest index) goes to the k-th lowest-index FU that is available.
// Ports:
// - match_i     [Depth]          entry holds a valid packet of this class
// - avail_i     [NumFu]          FU can accept a packet this cycle
// - sel_o       [NumFu][Depth]   one-hot entry select per FU (all zero if no grant)
// - consumed_o  [Depth]          entries granted this cycle
module fu_class_grant
    import fu_issue_buffer_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned NumFu = 1
) (
    input  logic [Depth-1:0]            match_i,
    input  logic [NumFu-1:0]            avail_i,
    output logic [NumFu-1:0][Depth-1:0] sel_o,
    output logic [Depth-1:0]            consumed_o
);

    logic [Depth-1:0] remaining;

    always_comb begin
        remaining = match_i;
        sel_o     = '0;
        for (int unsigned f = 0; f < NumFu; f++) begin
            if (avail_i[f]) begin
                // Isolate the lowest set bit: oldest still-unclaimed entry.
                sel_o[f]  = remaining & (~remaining + Depth'(1));
                remaining = remaining & ~sel_o[f];
            end
        end
        consumed_o = match_i & ~remaining;
    end

endmodule

// File: rtl/fu_issue_buffer.sv
// Issue buffer between the reservation station and the FU block.
// Holds issued packets in an age-ordered, compacting buffer (index 0 oldest) and presents, per FU class,
// the oldest pending packets to the available FUs. A presented packet is consumed on the next edge.
// Ports:
// - clock_i / reset_i         clock, asynchronous active-high reset
// - squash_i                  synchronous flush of all pending entries and of this cycle's rs lanes
// - rs_packet_i, rs_class_i   N issue lanes from the RS (lane 0 oldest)
// - *_avail_i                 per-FU ready masks from the FU block
// - fu_*_packet_o             packet presented to each FU (valid=0 when nothing is granted)
// - free_slots_o              registered empty-entry count, the RS issue credit
module fu_issue_buffer
    import fu_issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              squash_i,
    input  fu_packet_t [N-1:0]                rs_packet_i,
    input  fu_class_e  [N-1:0]                rs_class_i,
    input  logic [NUM_FU_ALU-1:0]             alu_avail_i,
    input  logic [NUM_FU_MULT-1:0]            mult_avail_i,
    input  logic [NUM_FU_LOAD-1:0]            load_avail_i,
    input  logic [NUM_FU_STORE-1:0]           store_avail_i,
    output fu_packet_t [NUM_FU_ALU-1:0]       fu_alu_packet_o,
    output fu_packet_t [NUM_FU_MULT-1:0]      fu_mult_packet_o,
    output fu_packet_t [NUM_FU_LOAD-1:0]      fu_load_packet_o,
    output fu_packet_t [NUM_FU_STORE-1:0]     fu_store_packet_o,
    output logic [$clog2(DEPTH+1)-1:0]        free_slots_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    ib_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [CntW-1:0]       free_slots_q, free_slots_d;

    logic [DEPTH-1:0] match_alu, match_mult, match_load, match_store;
    logic [DEPTH-1:0] cons_alu, cons_mult, cons_load, cons_store;
    logic [DEPTH-1:0] consumed;

    logic [NUM_FU_ALU-1:0][DEPTH-1:0]   sel_alu;
    logic [NUM_FU_MULT-1:0][DEPTH-1:0]  sel_mult;
    logic [NUM_FU_LOAD-1:0][DEPTH-1:0]  sel_load;
    logic [NUM_FU_STORE-1:0][DEPTH-1:0] sel_store;

    logic [CntW-1:0] fill;
    logic [CntW-1:0] taken;

    // Class match vectors, from registered state only (no rs -> FU bypass).
    always_comb begin
        match_alu   = '0;
        match_mult  = '0;
        match_load  = '0;
        match_store = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match_alu[i]   = entries_q[i].pkt.valid && (entries_q[i].cls == FU_ALU);
            match_mult[i]  = entries_q[i].pkt.valid && (entries_q[i].cls == FU_MULT);
            match_load[i]  = entries_q[i].pkt.valid && (entries_q[i].cls == FU_LOAD);
            match_store[i] = entries_q[i].pkt.valid && (entries_q[i].cls == FU_STORE);
        end
    end

    fu_class_grant #(.Depth(DEPTH), .NumFu(NUM_FU_ALU)) u_grant_alu (
        .match_i    (match_alu),
        .avail_i    (alu_avail_i),
        .sel_o      (sel_alu),
        .consumed_o (cons_alu)
    );

    fu_class_grant #(.Depth(DEPTH), .NumFu(NUM_FU_MULT)) u_grant_mult (
        .match_i    (match_mult),
        .avail_i    (mult_avail_i),
        .sel_o      (sel_mult),
        .consumed_o (cons_mult)
    );

    fu_class_grant #(.Depth(DEPTH), .NumFu(NUM_FU_LOAD)) u_grant_load (
        .match_i    (match_load),
        .avail_i    (load_avail_i),
        .sel_o      (sel_load),
        .consumed_o (cons_load)
    );

    fu_class_grant #(.Depth(DEPTH), .NumFu(NUM_FU_STORE)) u_grant_store (
        .match_i    (match_store),
        .avail_i    (store_avail_i),
        .sel_o      (sel_store),
        .consumed_o (cons_store)
    );

    function automatic fu_packet_t select_pkt(input ib_entry_t [DEPTH-1:0] ent,
                                              input logic [DEPTH-1:0]      sel);
        fu_packet_t pkt;
        pkt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                pkt = ent[i].pkt;
            end
        end
        return pkt;
    endfunction

    always_comb begin
        for (int unsigned f = 0; f < NUM_FU_ALU; f++) begin
            fu_alu_packet_o[f] = select_pkt(entries_q, sel_alu[f]);
        end
        for (int unsigned f = 0; f < NUM_FU_MULT; f++) begin
            fu_mult_packet_o[f] = select_pkt(entries_q, sel_mult[f]);
        end
        for (int unsigned f = 0; f < NUM_FU_LOAD; f++) begin
            fu_load_packet_o[f] = select_pkt(entries_q, sel_load[f]);
        end
        for (int unsigned f = 0; f < NUM_FU_STORE; f++) begin
            fu_store_packet_o[f] = select_pkt(entries_q, sel_store[f]);
        end
    end

    // Compact survivors, then append valid lanes in lane order up to the registered credit.
    // Slots freed by this cycle's grants are deliberately not offered to the RS until next cycle.
    always_comb begin
        consumed  = cons_alu | cons_mult | cons_load | cons_store;
        entries_d = '0;
        fill      = '0;
        taken     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].pkt.valid && !consumed[i]) begin
                entries_d[fill[IdxW-1:0]] = entries_q[i];
                fill = fill + CntW'(1);
            end
        end
        for (int unsigned l = 0; l < N; l++) begin
            if (rs_packet_i[l].valid && (taken < free_slots_q)) begin
                entries_d[fill[IdxW-1:0]].pkt = rs_packet_i[l];
                entries_d[fill[IdxW-1:0]].cls = rs_class_i[l];
                fill  = fill + CntW'(1);
                taken = taken + CntW'(1);
            end
        end
        if (squash_i) begin
            entries_d = '0;
            fill      = '0;
        end
        free_slots_d = CntW'(DEPTH) - fill;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            entries_q    <= '0;
            free_slots_q <= CntW'(DEPTH);
        end else begin
            entries_q    <= entries_d;
            free_slots_q <= free_slots_d;
        end
    end

    assign free_slots_o = free_slots_q;

    // The RS must never send more valid lanes than it has credit for.
    a_no_overrun: assert property (@(posedge clock_i) disable iff (reset_i)
        squash_i || (count_valid_lanes(rs_packet_i) <= 32'(free_slots_q)));

endmodule

// File: tb/tb_fu_issue_buffer.sv
module tb_fu_issue_buffer;
    import fu_issue_buffer_pkg::*;

    localparam int unsigned Depth = 8;
    localparam int NF = int'(NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD + NUM_FU_STORE);
    localparam int FuMult  = int'(NUM_FU_ALU);
    localparam int FuLoad  = int'(NUM_FU_ALU + NUM_FU_MULT);
    localparam int FuStore = int'(NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD);

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clock, reset, squash;
    fu_packet_t [N-1:0] rs_packet;
    fu_class_e  [N-1:0] rs_class;
    logic [NUM_FU_ALU-1:0]   alu_avail;
    logic [NUM_FU_MULT-1:0]  mult_avail;
    logic [NUM_FU_LOAD-1:0]  load_avail;
    logic [NUM_FU_STORE-1:0] store_avail;
    fu_packet_t [NUM_FU_ALU-1:0]   fu_alu_packet;
    fu_packet_t [NUM_FU_MULT-1:0]  fu_mult_packet;
    fu_packet_t [NUM_FU_LOAD-1:0]  fu_load_packet;
    fu_packet_t [NUM_FU_STORE-1:0] fu_store_packet;
    logic [3:0] free_slots;

    fu_issue_buffer #(.DEPTH(Depth)) dut (
        .clock_i           (clock),
        .reset_i           (reset),
        .squash_i          (squash),
        .rs_packet_i       (rs_packet),
        .rs_class_i        (rs_class),
        .alu_avail_i       (alu_avail),
        .mult_avail_i      (mult_avail),
        .load_avail_i      (load_avail),
        .store_avail_i     (store_avail),
        .fu_alu_packet_o   (fu_alu_packet),
        .fu_mult_packet_o  (fu_mult_packet),
        .fu_load_packet_o  (fu_load_packet),
        .fu_store_packet_o (fu_store_packet),
        .free_slots_o      (free_slots)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Flattened FU outputs: ALU 0..2, MULT 3..4, LOAD 5, STORE 6.
    fu_packet_t fu_out [NF];
    always_comb begin
        for (int i = 0; i < int'(NUM_FU_ALU); i++) fu_out[i] = fu_alu_packet[i];
        for (int i = 0; i < int'(NUM_FU_MULT); i++) fu_out[FuMult + i] = fu_mult_packet[i];
        for (int i = 0; i < int'(NUM_FU_LOAD); i++) fu_out[FuLoad + i] = fu_load_packet[i];
        for (int i = 0; i < int'(NUM_FU_STORE); i++) fu_out[FuStore + i] = fu_store_packet[i];
    end

    // Scoreboard queues, filled by the stimulus, drained by the monitor.
    exp_t exp_q [NF][$];
    exp_t free_q[$];
    int   idle_q[$];
    logic drain = 1'b0;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] opa_of(input int robn);
        return 32'(robn * 7 + 1);
    endfunction

    // Monitor: every issued packet must match the next expected one for that FU, in the expected cycle.
    exp_t mon_e;
    int   mon_c;
    logic anyv;
    always @(negedge clock) begin
        anyv = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (fu_out[f].valid) begin
                anyv = 1'b1;
                total++;
                if (exp_q[f].size() == 0) begin
                    bad++;
                    $display("FAIL issue fu%0d cyc=%0d: got robn=%0d, want no packet",
                             f, cyc, fu_out[f].robn);
                end else begin
                    mon_e = exp_q[f].pop_front();
                    if (mon_e.cyc != cyc || mon_e.val != int'(fu_out[f].robn) ||
                        fu_out[f].opa != opa_of(mon_e.val)) begin
                        bad++;
                        $display("FAIL issue fu%0d: got robn=%0d opa=%h cyc=%0d, want robn=%0d opa=%h cyc=%0d",
                                 f, fu_out[f].robn, fu_out[f].opa, cyc, mon_e.val,
                                 opa_of(mon_e.val), mon_e.cyc);
                    end
                end
            end
        end
        while (idle_q.size() != 0 && idle_q[0] <= cyc) begin
            mon_c = idle_q.pop_front();
            total++;
            if (mon_c != cyc || anyv) begin
                bad++;
                $display("FAIL idle cyc=%0d: got any_valid=%0b, want 0 (expected cyc %0d)",
                         cyc, anyv, mon_c);
            end
        end
        while (free_q.size() != 0 && free_q[0].cyc <= cyc) begin
            mon_e = free_q.pop_front();
            total++;
            if (mon_e.cyc != cyc || int'(free_slots) != mon_e.val) begin
                bad++;
                $display("FAIL free_slots cyc=%0d: got %0d, want %0d (expected cyc %0d)",
                         cyc, free_slots, mon_e.val, mon_e.cyc);
            end
        end
        if (drain) begin
            for (int f = 0; f < NF; f++) begin
                while (exp_q[f].size() != 0) begin
                    mon_e = exp_q[f].pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing fu%0d: got nothing, want robn=%0d at cyc %0d",
                             f, mon_e.val, mon_e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lane(input int l, input fu_class_e c, input int robn);
        rs_packet[l]       = '0;
        rs_packet[l].valid = 1'b1;
        rs_packet[l].robn  = ROB_IDX_W'(robn);
        rs_packet[l].opa   = opa_of(robn);
        rs_packet[l].opb   = 32'(robn);
        rs_class[l]        = c;
    endtask

    task automatic clr_lanes();
        rs_packet = '0;
        rs_class  = {N{FU_ALU}};
    endtask

    task automatic set_avail(input logic a);
        alu_avail   = {NUM_FU_ALU{a}};
        mult_avail  = {NUM_FU_MULT{a}};
        load_avail  = {NUM_FU_LOAD{a}};
        store_avail = {NUM_FU_STORE{a}};
    endtask

    task automatic exp_pkt(input int f, input int c, input int robn);
        exp_q[f].push_back('{cyc: c, val: robn});
    endtask

    task automatic exp_free(input int c, input int v);
        free_q.push_back('{cyc: c, val: v});
    endtask

    task automatic exp_idle(input int c);
        idle_q.push_back(c);
    endtask

    int c;

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        clr_lanes();
        set_avail(1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset release, no input.
        c = cyc;
        exp_idle(c);
        exp_free(c, 8);
        step();

        // Three ALU packets, all FUs available.
        set_avail(1'b1);
        lane(0, FU_ALU, 0); lane(1, FU_ALU, 1); lane(2, FU_ALU, 2);
        c = cyc;
        exp_pkt(0, c + 1, 0); exp_pkt(1, c + 1, 1); exp_pkt(2, c + 1, 2);
        exp_free(c + 1, 5);
        exp_idle(c + 2);
        exp_free(c + 2, 8);
        step(); clr_lanes();
        step();

        // Only ALU1 available: oldest goes to ALU1, the other waits for ALU0.
        alu_avail = 3'b010;
        lane(0, FU_ALU, 4); lane(1, FU_ALU, 5);
        c = cyc;
        exp_pkt(1, c + 1, 4);
        exp_free(c + 1, 6);
        exp_pkt(0, c + 2, 5);
        exp_free(c + 2, 7);
        exp_free(c + 3, 8);
        step(); clr_lanes();
        step(); alu_avail = 3'b111;
        step();

        // Mixed classes, MULT blocked for three cycles.
        set_avail(1'b1);
        mult_avail = '0;
        lane(0, FU_MULT, 8); lane(1, FU_ALU, 9); lane(2, FU_MULT, 10);
        c = cyc;
        exp_pkt(0, c + 1, 9);
        exp_free(c + 1, 5);
        step();
        lane(0, FU_LOAD, 11); lane(1, FU_MULT, 12); lane(2, FU_STORE, 13);
        exp_pkt(FuLoad, c + 2, 11);
        exp_pkt(FuStore, c + 2, 13);
        exp_free(c + 2, 3);
        step(); clr_lanes();
        exp_free(c + 3, 5);
        step();
        exp_free(c + 4, 5);
        step();
        mult_avail = '1;
        exp_pkt(FuMult, c + 4, 8);
        exp_pkt(FuMult + 1, c + 4, 10);
        exp_pkt(FuMult, c + 5, 12);
        exp_free(c + 5, 7);
        exp_free(c + 6, 8);
        step();
        step();

        // Fill to DEPTH with nothing available, then drain through the single LOAD unit.
        set_avail(1'b0);
        lane(0, FU_LOAD, 16); lane(1, FU_LOAD, 17); lane(2, FU_LOAD, 18);
        c = cyc;
        exp_free(c + 1, 5);
        step();
        lane(0, FU_LOAD, 19); lane(1, FU_LOAD, 20); lane(2, FU_LOAD, 21);
        exp_free(c + 2, 2);
        step();
        clr_lanes();
        lane(0, FU_LOAD, 22); lane(1, FU_LOAD, 23);
        exp_free(c + 3, 0);
        step(); clr_lanes();
        load_avail = 1'b1;
        for (int j = 0; j < 8; j++) exp_pkt(FuLoad, c + 3 + j, 16 + j);
        for (int j = 1; j <= 8; j++) exp_free(c + 3 + j, j);
        repeat (9) step();

        // Squash with five pending and three new lanes.
        set_avail(1'b0);
        lane(0, FU_ALU, 24); lane(1, FU_ALU, 25); lane(2, FU_ALU, 26);
        c = cyc;
        exp_free(c + 1, 5);
        step();
        clr_lanes();
        lane(0, FU_MULT, 27); lane(1, FU_MULT, 28);
        exp_free(c + 2, 3);
        step();
        squash = 1'b1;
        lane(0, FU_ALU, 29); lane(1, FU_ALU, 30); lane(2, FU_ALU, 31);
        exp_free(c + 3, 8);
        exp_idle(c + 3);
        exp_idle(c + 4);
        step();
        squash = 1'b0;
        clr_lanes();
        set_avail(1'b1);
        step();
        step();

        // Asynchronous reset mid-cycle clears pending entries without a clock edge.
        set_avail(1'b0);
        lane(0, FU_ALU, 1); lane(1, FU_ALU, 2);
        c = cyc;
        step(); clr_lanes();
        reset = 1'b1;
        set_avail(1'b1);
        #1;
        exp_idle(c + 1);
        exp_free(c + 1, 8);
        step();
        reset = 1'b0;
        step();
        step();

        drain = 1'b1;
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
